// File: rtl/eth_verdict_pkg.sv
// Shared definitions for the ethernet verdict stage: tuser field positions, port masks,
// verdict encodings and the verdict decision rule.
package eth_verdict_pkg;

    localparam int         SRC_PORT_POS  = 16;
    localparam int         DST_PORT_POS  = 24;
    localparam logic [7:0] CPU_PORT_MASK = 8'hAA;

    typedef enum logic [1:0] {
        VERDICT_DROP = 2'd0,
        VERDICT_FWD  = 2'd1,
        VERDICT_CPU  = 2'd2
    } verdict_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DROP
    } state_e;

    // First matching rule wins; packets that came from a CPU port are never dropped.
    function automatic verdict_e decide(input logic [7:0] sport, input logic for_us,
                                        input logic bmcast, input logic ipv4);
        if ((sport & CPU_PORT_MASK) != 8'h00) return VERDICT_FWD;
        if (!for_us)                          return VERDICT_DROP;
        if (ipv4 && !bmcast)                  return VERDICT_FWD;
        return VERDICT_CPU;
    endfunction

    // Each physical port's CPU queue sits one bit position above it.
    function automatic logic [7:0] cpu_port_of(input logic [7:0] sport);
        return {sport[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/eth_verdict_fifo.sv
// Small fallthrough FIFO: the head entry is visible on dout_o whenever empty_o is low.
// nearly_full_o asserts with one free slot left so a registered producer never overflows it.
module eth_verdict_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             nearly_full_o
);
    localparam int                  DEPTH    = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_CNT = (DEPTH_BITS + 1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] NEAR_CNT = (DEPTH_BITS + 1)'(DEPTH - 1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  do_wr, do_rd;

    assign do_wr = wr_en_i && (count_q != FULL_CNT);
    assign do_rd = rd_en_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign dout_o        = mem_q[rd_ptr_q];
    assign empty_o       = (count_q == '0);
    assign nearly_full_o = (count_q >= NEAR_CNT);

endmodule

// File: rtl/eth_verdict.sv
// Buffers ingress packets, pops one classifier result per packet and forwards, redirects to
// the CPU port or drops the whole packet. Define ETH_VERDICT_STATS_EN to add verdict counters.
module eth_verdict
    import eth_verdict_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int DFIFO_DEPTH_BITS     = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic                              o_pkt_word1,
    input  logic                              i_is_for_us,
    input  logic                              i_is_bmcast,
    input  logic                              i_is_arp,
    input  logic                              i_is_ipv4,
    input  logic                              i_eth_out_valid,
    output logic                              o_rd_from_magic,
`ifdef ETH_VERDICT_STATS_EN
    output logic [31:0]                       o_cnt_drop,
    output logic [31:0]                       o_cnt_cpu,
    output logic [31:0]                       o_cnt_fwd,
`endif
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready
);
    localparam int STRB_W  = C_S_AXIS_TDATA_WIDTH / 8;
    localparam int ENTRY_W = 1 + C_S_AXIS_TUSER_WIDTH + STRB_W + C_S_AXIS_TDATA_WIDTH;

    logic [ENTRY_W-1:0]              head;
    logic                            hd_last;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] hd_user;
    logic                            empty, nearly_full, push, pop;
    state_e                          state_q, state_d;
    logic                            rewrite_q, rewrite_d;
    logic                            sof_q, sof_d;
    logic                            r_first_q, r_first_d;
    verdict_e                        verdict;
    logic                            unused_arp;

    // ARP is already covered by the catch-all CPU rule, so the flag carries no extra information.
    assign unused_arp = i_is_arp;

    assign s_axis_tready = !nearly_full && !reset;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign o_pkt_word1   = push && r_first_q;

    eth_verdict_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_BITS (DFIFO_DEPTH_BITS)
    ) u_dfifo (
        .clk           (clk),
        .reset         (reset),
        .wr_en_i       (push),
        .din_i         ({s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata}),
        .rd_en_i       (pop),
        .dout_o        (head),
        .empty_o       (empty),
        .nearly_full_o (nearly_full)
    );

    assign {hd_last, hd_user, m_axis_tstrb, m_axis_tdata} = head;
    assign m_axis_tlast = hd_last;
    assign verdict = decide(hd_user[SRC_PORT_POS +: 8], i_is_for_us, i_is_bmcast, i_is_ipv4);

    always_comb begin
        r_first_d = r_first_q;
        if (push) r_first_d = s_axis_tlast;
    end

    always_comb begin
        state_d         = state_q;
        rewrite_d       = rewrite_q;
        sof_d           = sof_q;
        o_rd_from_magic = 1'b0;
        m_axis_tvalid   = 1'b0;
        pop             = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && i_eth_out_valid) begin
                    o_rd_from_magic = 1'b1;
                    sof_d           = 1'b1;
                    rewrite_d       = (verdict == VERDICT_CPU);
                    state_d         = (verdict == VERDICT_DROP) ? ST_DROP : ST_SEND;
                end
            end
            ST_SEND: begin
                m_axis_tvalid = !empty;
                if (!empty && m_axis_tready) begin
                    pop   = 1'b1;
                    sof_d = 1'b0;
                    if (hd_last) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (hd_last) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Only the header word carries the destination port; later words pass untouched.
    always_comb begin
        m_axis_tuser = hd_user;
        if (rewrite_q && sof_q)
            m_axis_tuser[DST_PORT_POS +: 8] = cpu_port_of(hd_user[SRC_PORT_POS +: 8]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rewrite_q <= 1'b0;
            sof_q     <= 1'b0;
            r_first_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rewrite_q <= rewrite_d;
            sof_q     <= sof_d;
            r_first_q <= r_first_d;
        end
    end

`ifdef ETH_VERDICT_STATS_EN
    logic [31:0] cnt_drop_q, cnt_cpu_q, cnt_fwd_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_drop_q <= '0;
            cnt_cpu_q  <= '0;
            cnt_fwd_q  <= '0;
        end else if (o_rd_from_magic) begin
            case (verdict)
                VERDICT_DROP: cnt_drop_q <= cnt_drop_q + 32'd1;
                VERDICT_CPU:  cnt_cpu_q  <= cnt_cpu_q + 32'd1;
                default:      cnt_fwd_q  <= cnt_fwd_q + 32'd1;
            endcase
        end
    end

    assign o_cnt_drop = cnt_drop_q;
    assign o_cnt_cpu  = cnt_cpu_q;
    assign o_cnt_fwd  = cnt_fwd_q;
`endif

endmodule

// File: tb/tb_eth_verdict.sv
// Bench for eth_verdict: directed packet scenarios plus a randomized run, checked against a
// packet-level model of the forward / CPU-redirect / drop rules.
module tb_eth_verdict;
    localparam int TD = 256;
    localparam int TU = 128;
    localparam int TS = 32;

    typedef struct packed {
        logic          last;
        logic [TU-1:0] user;
        logic [TS-1:0] strb;
        logic [TD-1:0] data;
    } beat_t;

    typedef struct packed {
        logic for_us;
        logic bmcast;
        logic arp;
        logic ipv4;
    } cls_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [TD-1:0] s_axis_tdata = '0;
    logic [TS-1:0] s_axis_tstrb = '0;
    logic [TU-1:0] s_axis_tuser = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic          o_pkt_word1;
    logic          i_is_for_us = 1'b0, i_is_bmcast = 1'b0, i_is_arp = 1'b0, i_is_ipv4 = 1'b0;
    logic          i_eth_out_valid = 1'b0;
    logic          o_rd_from_magic;
    logic [TD-1:0] m_axis_tdata;
    logic [TS-1:0] m_axis_tstrb;
    logic [TU-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready = 1'b1;

    always #5 clk = ~clk;

    eth_verdict dut (
        .clk             (clk),
        .reset           (reset),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tstrb    (s_axis_tstrb),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tready   (s_axis_tready),
        .o_pkt_word1     (o_pkt_word1),
        .i_is_for_us     (i_is_for_us),
        .i_is_bmcast     (i_is_bmcast),
        .i_is_arp        (i_is_arp),
        .i_is_ipv4       (i_is_ipv4),
        .i_eth_out_valid (i_eth_out_valid),
        .o_rd_from_magic (o_rd_from_magic),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tstrb    (m_axis_tstrb),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready)
    );

    int    total = 0;
    int    bad = 0;
    int    pkts_sent = 0;
    int    rd_cnt = 0;
    int    w1_cnt = 0;
    int    rdy_hold = 0;
    bit    rdy_rand = 1'b0;
    bit    stall_seen = 1'b0;
    bit    hold_prev = 1'b0;
    logic  w1_s = 1'b0, rd_s = 1'b0;
    beat_t prev_beat;
    beat_t exp_q[$];
    beat_t obs_q[$];
    cls_t  cls_by_pkt[$];
    cls_t  res_q[$];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [TD-1:0] rnd256();
        logic [TD-1:0] r;
        for (int i = 0; i < TD / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Output monitor and classifier-side observations, sampled mid-cycle.
    always @(negedge clk) begin
        beat_t cur;
        cur = {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata};
        w1_s = o_pkt_word1;
        rd_s = o_rd_from_magic;
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (o_rd_from_magic) rd_cnt++;
            if (s_axis_tvalid && !s_axis_tready) stall_seen = 1'b1;
            if (m_axis_tvalid && m_axis_tready) obs_q.push_back(cur);
            if (hold_prev) check("egress_hold", 512'({m_axis_tvalid, cur}), 512'({1'b1, prev_beat}));
            hold_prev = m_axis_tvalid && !m_axis_tready;
            prev_beat = cur;
        end
    end

    // Classifier result FIFO model and egress back-pressure.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            res_q.delete();
        end else begin
            if (rd_s && res_q.size() > 0) void'(res_q.pop_front());
            if (w1_s) begin
                if (w1_cnt < cls_by_pkt.size()) res_q.push_back(cls_by_pkt[w1_cnt]);
                w1_cnt++;
            end
        end
        i_eth_out_valid = (res_q.size() != 0);
        if (res_q.size() != 0) begin
            i_is_for_us = res_q[0].for_us;
            i_is_bmcast = res_q[0].bmcast;
            i_is_arp    = res_q[0].arp;
            i_is_ipv4   = res_q[0].ipv4;
        end
        if (rdy_hold > 0) begin
            m_axis_tready = 1'b0;
            rdy_hold--;
        end else begin
            m_axis_tready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Drives one packet and appends what should come out of the egress port.
    task automatic send_pkt(input int n, input logic [7:0] sport, input cls_t c, input int gap_max);
        beat_t b, e;
        bit    cpu_src, drop, rew;
        int    k;
        cpu_src = (sport & 8'hAA) != 8'h00;
        drop    = !cpu_src && !c.for_us;
        rew     = !cpu_src && c.for_us && !(c.ipv4 && !c.bmcast);
        cls_by_pkt.push_back(c);
        pkts_sent++;
        for (int i = 0; i < n; i++) begin
            b.data = rnd256();
            b.strb = (i == n - 1) ? $urandom : 32'hFFFF_FFFF;
            b.user = {$urandom, $urandom, $urandom, $urandom};
            b.user[23:16] = sport;
            b.last = (i == n - 1);
            if (!drop) begin
                e = b;
                if (i == 0 && rew) e.user[31:24] = sport * 2;
                exp_q.push_back(e);
            end
            s_axis_tdata  = b.data;
            s_axis_tstrb  = b.strb;
            s_axis_tuser  = b.user;
            s_axis_tlast  = b.last;
            s_axis_tvalid = 1'b1;
            k = 0;
            forever begin
                @(negedge clk);
                if (s_axis_tready) begin
                    check("word1", 512'(o_pkt_word1), 512'(i == 0));
                    break;
                end
                k++;
                if (k > 300) begin
                    total++;
                    bad++;
                    $error("FAIL accept_timeout: observed=%0d cycles expected<=300", k);
                    break;
                end
            end
            @(posedge clk); #1;
            s_axis_tvalid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic drain_and_compare(input string tag);
        int k = 0;
        while (obs_q.size() < exp_q.size() && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (12) begin
            @(posedge clk); #1;
        end
        check({tag, "_beats"}, 512'(obs_q.size()), 512'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check({tag, "_beat"}, 512'(obs_q[i]), 512'(exp_q[i]));
        check({tag, "_rd_pulses"}, 512'(rd_cnt), 512'(pkts_sent));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] sports [9];
        sports = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};

        // Reset values, with a beat offered so word1 and tready are meaningful.
        s_axis_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 512'({s_axis_tready, m_axis_tvalid, o_rd_from_magic, o_pkt_word1}), 512'(0));
        s_axis_tvalid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;

        // IPv4 unicast, ARP redirect, drop then normal, back-to-back single-beat CPU packets.
        send_pkt(3, 8'h01, 4'b1001, 0);
        drain_and_compare("ipv4_fwd");
        send_pkt(2, 8'h04, 4'b1010, 0);
        drain_and_compare("arp_cpu");
        send_pkt(4, 8'h10, 4'b0001, 0);
        send_pkt(2, 8'h10, 4'b1001, 0);
        drain_and_compare("drop_then_fwd");
        send_pkt(1, 8'h02, 4'b0000, 0);
        send_pkt(1, 8'h02, 4'b1100, 0);
        drain_and_compare("cpu_src");
        send_pkt(2, 8'h40, 4'b1101, 0);
        drain_and_compare("bmcast_cpu");

        // Egress blocked while several 6-word packets arrive.
        stall_seen = 1'b0;
        rdy_hold = 20;
        for (int p = 0; p < 4; p++) send_pkt(6, 8'h01, 4'b1001, 0);
        drain_and_compare("stall");
        check("stall_seen", 512'(stall_seen), 512'(1));

        // Reset while a packet sits in SEND with egress blocked.
        rdy_hold = 100000;
        send_pkt(6, 8'h01, 4'b1001, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("send_before_reset", 512'(m_axis_tvalid), 512'(1));
        @(posedge clk); #2;
        reset = 1'b1;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        check("midsend_reset_outs",
              512'({s_axis_tready, m_axis_tvalid, o_rd_from_magic, o_pkt_word1}), 512'(0));
        @(posedge clk); #2;
        s_axis_tvalid = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        obs_q.delete();
        rdy_hold = 0;
        @(posedge clk); #1;
        send_pkt(2, 8'h04, 4'b1001, 0);
        drain_and_compare("after_reset");

        // Randomized traffic with random egress back-pressure.
        rdy_rand = 1'b1;
        for (int p = 0; p < 30; p++) begin
            logic [7:0] sp;
            cls_t       c;
            sp = sports[$urandom_range(0, 8)];
            if (sp == 8'h00) sp = 8'($urandom);
            c = 4'($urandom);
            send_pkt($urandom_range(1, 6), sp, c, 2);
        end
        drain_and_compare("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

endmodule
